lsu_mem_stage: RTL

- MEM-stage load/store controller sitting directly upstream of the data memory.
- Accepts load/store requests from EX with a valid/ready handshake and computes the effective address (base + sign-extended offset).
- Drives the data memory's address, data_in and write_en.
- Captures the memory's registered read data (one-cycle read latency) and returns load results to WB via a valid/ready response port.

---
 rtl/lsu_mem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : MEM-stage load/store controller. Computes the effective address,
//            drives the data memory and returns load data to WB.
//            Optional LSU_PERF_CNT_EN adds saturating load/store counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 8,
    parameter int OFFW  = 8,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [DSIZE-1:0] req_base,
    input  logic [OFFW-1:0]  req_offset,
    input  logic [DSIZE-1:0] req_wdata,
    input  logic [TAGW-1:0]  req_tag,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DSIZE-1:0] rsp_data,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             addr_err
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0]      ld_cnt,
    output logic [15:0]      st_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ASIZE-1:0]   r_addr;
    logic [DSIZE-1:0]   r_rsp_data;
    logic [TAGW-1:0]    r_rsp_tag;
    logic               r_addr_err;

    logic [DSIZE-1:0]   w_offset_sext;
    logic [DSIZE-1:0]   w_ea;
    logic               w_in_range;
    logic               w_ld_accept;
    logic               w_st_accept;
    logic               w_err;

    assign w_offset_sext = {{(DSIZE-OFFW){req_offset[OFFW-1]}}, req_offset};
    assign w_ea          = req_base + w_offset_sext;
    assign w_in_range    = (w_ea[DSIZE-1:ASIZE] == '0);

    assign mem_wdata = req_wdata;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign addr_err  = r_addr_err;

    // Requests are only taken in IDLE and never while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_addr;
        w_ld_accept = 1'b0;
        w_st_accept = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = rst;
                mem_addr  = w_ea[ASIZE-1:0];
                if (req_valid && rst) begin
                    if (!w_in_range) begin
                        w_err = 1'b1;
                    end else if (req_write) begin
                        mem_we      = 1'b1;
                        w_st_accept = 1'b1;
                    end else begin
                        w_ld_accept = 1'b1;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_err <= w_err;
            if (w_ld_accept) begin
                r_addr    <= w_ea[ASIZE-1:0];
                r_rsp_tag <= req_tag;
            end
            // Memory read data is valid one cycle after the address was sampled.
            if (r_state == RD_WAIT) begin
                r_rsp_data <= mem_rdata;
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [15:0] r_ld_cnt;
    logic [15:0] r_st_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ld_cnt <= '0;
            r_st_cnt <= '0;
        end else begin
            if (w_ld_accept && (r_ld_cnt != 16'hFFFF)) begin
                r_ld_cnt <= r_ld_cnt + 16'd1;
            end
            if (w_st_accept && (r_st_cnt != 16'hFFFF)) begin
                r_st_cnt <= r_st_cnt + 16'd1;
            end
        end
    end

    assign ld_cnt = r_ld_cnt;
    assign st_cnt = r_st_cnt;
`endif

endmodule

`default_nettype wire
